// File: rtl/valid_strobe_gen.sv
// Producer of the one-cycle advance strobe for the LED shift block: free-running
// pulses at one of four switch-selected periods, or one pulse per step-button press.
module valid_strobe_gen #(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned COUNT_0    = 50_000_000,
  parameter int unsigned COUNT_1    = 25_000_000,
  parameter int unsigned COUNT_2    = 12_500_000,
  parameter int unsigned COUNT_3    = 100_000_000,
  parameter int unsigned NB_TICKS   = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [3:0]          i_sw,
  input  logic                i_step,
  output logic                o_valid,
  output logic [NB_TICKS-1:0] o_tick_count
);

  typedef enum logic [1:0] {
    MODE_DISABLED,
    MODE_FREE_RUN,
    MODE_STEP
  } mode_e;

  localparam logic [NB_COUNTER-1:0] LAST_0 = NB_COUNTER'(COUNT_0 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_1 = NB_COUNTER'(COUNT_1 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_2 = NB_COUNTER'(COUNT_2 - 1);
  localparam logic [NB_COUNTER-1:0] LAST_3 = NB_COUNTER'(COUNT_3 - 1);

  mode_e                 mode;
  logic [NB_COUNTER-1:0] count_q, count_d;
  logic [NB_COUNTER-1:0] last_count;
  logic [1:0]            sel_q;
  logic                  step_q;
  logic                  valid_q, valid_d;
  logic [NB_TICKS-1:0]   tick_q, tick_d;
  logic                  sel_change;
  logic                  step_rise;

  always_comb begin
    mode = MODE_DISABLED;
    if (i_sw[0]) begin
      mode = i_sw[3] ? MODE_STEP : MODE_FREE_RUN;
    end
  end

  always_comb begin
    last_count = LAST_0;
    unique case (i_sw[2:1])
      2'd0: last_count = LAST_0;
      2'd1: last_count = LAST_1;
      2'd2: last_count = LAST_2;
      2'd3: last_count = LAST_3;
    endcase
  end

  assign sel_change = (i_sw[2:1] != sel_q);
  assign step_rise  = i_step & ~step_q;

  // Counter only advances in FREE_RUN, so leaving that mode always parks it at 0
  // and every new free-running period starts from a clean count.
  always_comb begin
    count_d = '0;
    valid_d = 1'b0;
    if (mode == MODE_DISABLED || sel_change) begin
      count_d = '0;
      valid_d = 1'b0;
    end else if (mode == MODE_FREE_RUN) begin
      if (count_q == last_count) begin
        valid_d = 1'b1;
      end else begin
        count_d = count_q + NB_COUNTER'(1);
      end
    end else begin
      valid_d = step_rise;
    end
    tick_d = valid_d ? tick_q + NB_TICKS'(1) : tick_q;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
      sel_q   <= 2'd0;
      step_q  <= 1'b0;
      valid_q <= 1'b0;
      tick_q  <= '0;
    end else begin
      count_q <= count_d;
      sel_q   <= i_sw[2:1];
      step_q  <= i_step;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_tick_count = tick_q;

endmodule

// File: tb/tb_valid_strobe_gen.sv
// Scenario bench for valid_strobe_gen with short periods (4, 2, 1, 8) and a 4-bit
// tick counter; expected outputs are queued per cycle and popped after each edge.
module tb_valid_strobe_gen;

  localparam int NB_TICKS = 4;

  typedef struct {
    logic                valid;
    logic [NB_TICKS-1:0] tick;
  } exp_t;

  logic                clock = 1'b0;
  logic                i_reset;
  logic [3:0]          i_sw;
  logic                i_step;
  logic                o_valid;
  logic [NB_TICKS-1:0] o_tick_count;

  exp_t expQ[$];
  int   passCount  = 0;
  int   checkCount = 0;
  int   expTick    = 0;

  valid_strobe_gen #(
    .NB_COUNTER(32),
    .COUNT_0   (4),
    .COUNT_1   (2),
    .COUNT_2   (1),
    .COUNT_3   (8),
    .NB_TICKS  (NB_TICKS)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_sw        (i_sw),
    .i_step      (i_step),
    .o_valid     (o_valid),
    .o_tick_count(o_tick_count)
  );

  always #5 clock = ~clock;

  // Drives one cycle of inputs and queues what the outputs must show after the next edge.
  task automatic applyStimulus(input logic [3:0] sw, input logic step, input logic expValid);
    exp_t e;
    i_sw   = sw;
    i_step = step;
    if (expValid) expTick = (expTick + 1) % 16;
    e.valid = expValid;
    e.tick  = NB_TICKS'(expTick);
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_sw    = 4'b0001;
    i_step  = 1'b0;
    expTick = 0;
    repeat (2) @(posedge clock);
    #1;
    checkCount++;
    if (o_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", o_valid);
    else passCount++;
    checkCount++;
    if (o_tick_count !== 4'd0) $display("[TB] FAIL reset_tick: got %0d expected 0", o_tick_count);
    else passCount++;
    i_reset = 1'b1;
  endtask

  task automatic test_free_run();
    exp_t e;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(4'b0001, 1'b0, (c % 4) == 0);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL free_run_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL free_run_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  task automatic test_speed_change();
    exp_t       e;
    logic [3:0] swSeq[13] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0111, 4'b0111,
                              4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    logic       vSeq[13]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int c = 0; c < 13; c++) begin
      applyStimulus(swSeq[c], 1'b0, vSeq[c]);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL speed_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL speed_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  task automatic test_step();
    exp_t e;
    logic stepSeq[10] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    logic vSeq[10]    = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b1111, stepSeq[c], vSeq[c]);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL step_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL step_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  task automatic test_disable();
    exp_t       e;
    logic [3:0] sw;
    logic       v;
    for (int c = 0; c < 23; c++) begin
      sw = (c >= 5 && c < 15) ? 4'b0110 : 4'b0111;
      v  = (c == 22);
      applyStimulus(sw, 1'b0, v);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL disable_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL disable_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    #2;
    i_reset = 1'b0;
    i_sw    = 4'b0101;
    expTick = 0;
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b1;
    for (int c = 0; c < 18; c++) begin
      applyStimulus(4'b0101, 1'b0, c != 0);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL wrap_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL wrap_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0111, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL pre_reset_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
    #2;
    i_reset = 1'b0;
    #1;
    checkCount++;
    if (o_valid !== 1'b0) $display("[TB] FAIL async_reset_valid: got %b expected 0", o_valid);
    else passCount++;
    checkCount++;
    if (o_tick_count !== 4'd0) $display("[TB] FAIL async_reset_tick: got %0d expected 0", o_tick_count);
    else passCount++;
    expTick = 0;
    i_sw = 4'b0001;
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(4'b0001, 1'b0, c == 4);
      @(posedge clock);
      #1;
      e = expQ.pop_front();
      checkCount++;
      if (o_valid !== e.valid)
        $display("[TB] FAIL post_reset_valid cycle %0d: got %b expected %b", c, o_valid, e.valid);
      else passCount++;
      checkCount++;
      if (o_tick_count !== e.tick)
        $display("[TB] FAIL post_reset_tick cycle %0d: got %0d expected %0d", c, o_tick_count, e.tick);
      else passCount++;
    end
  endtask

  initial begin
    $display("[TB] starting valid_strobe_gen bench");
    test_reset();
    test_free_run();
    test_speed_change();
    test_step();
    test_disable();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
